// File: rtl/instr_sequencer.sv
// Instruction sequencer: issues one-hot phase strobes (fetch, decode, per-micro-op
// select/execute, EIP update), stalls on fetch_ready, halts at instruction boundaries.
module instr_sequencer #(
    parameter int CNT_W   = 32,
    parameter int MAX_OPS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_ready,
    input  logic [3:0]       num_of_ope,
    input  logic             halt_req,
    output logic             ph_fetch,
    output logic             ph_decode,
    output logic [2:0]       ph_sel,
    output logic [2:0]       ph_exec,
    output logic             ph_eip,
    output logic [1:0]       op_idx,
    output logic [1:0]       ops_latched,
    output logic             illegal_ops,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_dbg
);

    localparam logic [2:0] ST_RST      = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_DECODE   = 3'd2;
    localparam logic [2:0] ST_DISPATCH = 3'd3;
    localparam logic [2:0] ST_SEL      = 3'd4;
    localparam logic [2:0] ST_EXEC     = 3'd5;
    localparam logic [2:0] ST_EIPUPD   = 3'd6;
    localparam logic [2:0] ST_HALT     = 3'd7;

    localparam logic [3:0] MAX_N = 4'(MAX_OPS);

    logic [2:0] state;
    logic [2:0] next_state;

    // Handshake: a fetch is accepted in any FETCH cycle where fetch_ready is high;
    // ph_fetch mirrors that acceptance and the FSM advances on the same edge.
    always_comb begin
        next_state = state;
        case (state)
            ST_RST:      next_state = ST_FETCH;
            ST_FETCH:    next_state = fetch_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:   next_state = ST_DISPATCH;
            ST_DISPATCH: next_state = (num_of_ope == 4'd0) ? ST_EIPUPD : ST_SEL;
            ST_SEL:      next_state = ST_EXEC;
            ST_EXEC:     next_state = (op_idx < ops_latched) ? ST_SEL : ST_EIPUPD;
            ST_EIPUPD:   next_state = halt_req ? ST_HALT : ST_FETCH;
            ST_HALT:     next_state = halt_req ? ST_HALT : ST_FETCH;
            default:     next_state = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RST;
            op_idx      <= 2'd0;
            ops_latched <= 2'd0;
            illegal_ops <= 1'b0;
            retired     <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_DISPATCH: begin
                    // Oversized counts are clamped so the datapath never sees a 4th slot.
                    if (num_of_ope > MAX_N) begin
                        ops_latched <= 2'd3;
                        illegal_ops <= 1'b1;
                        op_idx      <= 2'd1;
                    end else begin
                        ops_latched <= num_of_ope[1:0];
                        op_idx      <= (num_of_ope == 4'd0) ? 2'd0 : 2'd1;
                    end
                end
                ST_EXEC: begin
                    op_idx <= (op_idx < ops_latched) ? op_idx + 2'd1 : 2'd0;
                end
                ST_EIPUPD: begin
                    retired <= retired + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ph_fetch  = (state == ST_FETCH) && fetch_ready;
        ph_decode = (state == ST_DECODE);
        ph_sel    = (state == ST_SEL)  ? (3'b001 << (op_idx - 2'd1)) : 3'b000;
        ph_exec   = (state == ST_EXEC) ? (3'b001 << (op_idx - 2'd1)) : 3'b000;
        ph_eip    = (state == ST_EIPUPD);
        halted    = (state == ST_HALT);
        state_dbg = state;
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: checks strobe order per cycle, stalls, halt,
// illegal micro-op counts and mid-instruction reset against hand-computed values.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_ready;
    logic [3:0]  num_of_ope;
    logic        halt_req;
    logic        ph_fetch;
    logic        ph_decode;
    logic [2:0]  ph_sel;
    logic [2:0]  ph_exec;
    logic        ph_eip;
    logic [1:0]  op_idx;
    logic [1:0]  ops_latched;
    logic        illegal_ops;
    logic        halted;
    logic [31:0] retired;
    logic [2:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    // Packed strobe view: {fetch, decode, sel[2:0], exec[2:0], eip}
    logic [8:0] strobes;
    assign strobes = {ph_fetch, ph_decode, ph_sel, ph_exec, ph_eip};

    localparam logic [8:0] S_NONE   = 9'b0_0_000_000_0;
    localparam logic [8:0] S_FETCH  = 9'b1_0_000_000_0;
    localparam logic [8:0] S_DECODE = 9'b0_1_000_000_0;
    localparam logic [8:0] S_EIP    = 9'b0_0_000_000_1;

    instr_sequencer #(.CNT_W(32), .MAX_OPS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_ready (fetch_ready),
        .num_of_ope  (num_of_ope),
        .halt_req    (halt_req),
        .ph_fetch    (ph_fetch),
        .ph_decode   (ph_decode),
        .ph_sel      (ph_sel),
        .ph_exec     (ph_exec),
        .ph_eip      (ph_eip),
        .op_idx      (op_idx),
        .ops_latched (ops_latched),
        .illegal_ops (illegal_ops),
        .halted      (halted),
        .retired     (retired),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] s_sel(input int k);
        logic [8:0] v;
        v = 9'b0_0_001_000_0;
        return v << (k - 1);
    endfunction

    function automatic logic [8:0] s_exec(input int k);
        logic [8:0] v;
        v = 9'b0_0_000_001_0;
        return v << (k - 1);
    endfunction

    task automatic chk_reset_values(input string tag);
        chk({tag, "_strobes"}, 32'(strobes), 32'(S_NONE));
        chk({tag, "_op_idx"}, 32'(op_idx), 32'd0);
        chk({tag, "_ops_latched"}, 32'(ops_latched), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_ops), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_retired"}, retired, 32'd0);
    endtask

    // Starts in a FETCH cycle; walks one instruction cycle by cycle, ends in the
    // cycle after EIPUPD. halt_op2 raises halt_req during EXEC of micro-op 2.
    task automatic instr(input string tag, input int n, input int stalls, input bit halt_op2);
        for (int s = 0; s < stalls; s++) begin
            fetch_ready = 1'b0;
            #1;
            chk({tag, "_stall"}, 32'(strobes), 32'(S_NONE));
            chk({tag, "_stall_state"}, 32'(state_dbg), 32'd1);
            tick();
        end
        fetch_ready = 1'b1;
        #1;
        chk({tag, "_fetch"}, 32'(strobes), 32'(S_FETCH));
        tick();
        chk({tag, "_decode"}, 32'(strobes), 32'(S_DECODE));
        tick();
        chk({tag, "_dispatch"}, 32'(strobes), 32'(S_NONE));
        tick();
        for (int k = 1; k <= n; k++) begin
            chk({tag, "_sel"}, 32'(strobes), 32'(s_sel(k)));
            chk({tag, "_sel_idx"}, 32'(op_idx), 32'(k));
            tick();
            chk({tag, "_exec"}, 32'(strobes), 32'(s_exec(k)));
            if (halt_op2 && k == 2) halt_req = 1'b1;
            tick();
        end
        chk({tag, "_eip"}, 32'(strobes), 32'(S_EIP));
        chk({tag, "_eip_idx"}, 32'(op_idx), 32'd0);
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        fetch_ready = 1'b1;
        num_of_ope  = 4'd3;
        halt_req    = 1'b0;
        tick();
        tick();
        chk_reset_values("reset");

        // Release: one RST cycle, then FETCH.
        reset = 1'b0;
        #1;
        chk("rst_cycle", 32'(strobes), 32'(S_NONE));
        tick();

        // Three n=3 instructions back to back: 30 cycles, retired 3.
        instr("n3_a", 3, 0, 1'b0);
        instr("n3_b", 3, 0, 1'b0);
        instr("n3_c", 3, 0, 1'b0);
        chk("retired_after_3", retired, 32'd3);

        // n = 0, 1, 2
        num_of_ope = 4'd0;
        instr("n0", 0, 0, 1'b0);
        chk("ops_latched_n0", 32'(ops_latched), 32'd0);
        num_of_ope = 4'd1;
        instr("n1", 1, 0, 1'b0);
        num_of_ope = 4'd2;
        instr("n2", 2, 0, 1'b0);
        chk("ops_latched_n2", 32'(ops_latched), 32'd2);
        chk("retired_after_6", retired, 32'd6);

        // Five stall cycles in FETCH.
        num_of_ope = 4'd1;
        instr("stall5", 1, 5, 1'b0);
        chk("retired_after_stall", retired, 32'd7);

        // Halt raised mid-instruction; instruction still completes.
        num_of_ope = 4'd3;
        instr("halt_n3", 3, 0, 1'b1);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_strobes", 32'(strobes), 32'(S_NONE));
        chk("halt_retired", retired, 32'd8);
        tick();
        tick();
        chk("halt_held", 32'(halted), 32'd1);
        chk("halt_held_strobes", 32'(strobes), 32'(S_NONE));
        halt_req = 1'b0;
        #1;
        chk("halt_release_cycle", 32'(halted), 32'd1);
        tick();
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_retired", retired, 32'd8);

        // Illegal micro-op count clamps to 3 and sets a sticky flag.
        num_of_ope = 4'd7;
        instr("illegal7", 3, 0, 1'b0);
        chk("illegal_set", 32'(illegal_ops), 32'd1);
        chk("illegal_clamp", 32'(ops_latched), 32'd3);
        num_of_ope = 4'd1;
        instr("after_illegal", 1, 0, 1'b0);
        chk("illegal_sticky", 32'(illegal_ops), 32'd1);
        chk("ops_latched_n1", 32'(ops_latched), 32'd1);
        chk("retired_after_illegal", retired, 32'd10);

        // Reset during SEL of micro-op 2.
        num_of_ope = 4'd3;
        chk("mr_fetch", 32'(strobes), 32'(S_FETCH));
        tick();
        chk("mr_decode", 32'(strobes), 32'(S_DECODE));
        tick();
        tick();
        chk("mr_sel1", 32'(strobes), 32'(s_sel(1)));
        tick();
        chk("mr_exec1", 32'(strobes), 32'(s_exec(1)));
        tick();
        chk("mr_sel2", 32'(strobes), 32'(s_sel(2)));
        reset = 1'b1;
        tick();
        chk_reset_values("midreset");
        reset = 1'b0;
        #1;
        chk("mr_rst_cycle", 32'(strobes), 32'(S_NONE));
        tick();
        num_of_ope = 4'd1;
        instr("post_reset", 1, 0, 1'b0);
        chk("post_reset_retired", retired, 32'd1);
        chk("post_reset_illegal", 32'(illegal_ops), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Synchronous single-clock instruction sequencer that replaces the free-running 12-phase ring counter driving the multi-cycle datapath. It issues one-hot phase strobes in order: fetch, decode, per-micro-op select/execute, and EIP update. Only the micro-ops reported by decode (`num_of_ope`) are issued. It also stalls on a fetch-ready handshake, halts at instruction boundaries, and counts retired instructions. It sits between the top level and fetch/decode/selector/alu/alu_result_selector/register blocks, which consume its strobes as phase enables.

## Interface
- `CNT_W`, default 32: width of retired-instruction counter.
- `MAX_OPS`, default 3: maximum micro-ops per instruction; must be 3 (matches the select/reg_load slots in decode).

Ports:
- `clk`  in  1: system clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `fetch_ready`  in  1: fetch data valid this cycle; held low stalls FETCH.
- `num_of_ope`  in  4: micro-op count from decode, valid from the cycle after the DECODE strobe.
- `halt_req`  in  1: request to stop at the next instruction boundary (level).
- `ph_fetch`  out  1: fetch strobe (one cycle per accepted fetch).
- `ph_decode`  out  1: decode strobe.
- `ph_sel`  out  3: one-hot select strobe; bit k = micro-op k+1.
- `ph_exec`  out  3: one-hot ALU/load strobe; bit k = micro-op k+1.
- `ph_eip`  out  1: EIP advance strobe.
- `op_idx`  out  2: current micro-op (1..3), 0 outside SEL/EXEC.
- `ops_latched`  out  2: micro-op count latched for the current instruction.
- `illegal_ops`  out  1: sticky; set when `num_of_ope` > 3 is sampled.
- `halted`  out  1: high while in HALT.
- `retired`  out  CNT_W: count of completed instructions.

## Operation
- States: RST, FETCH, DECODE, DISPATCH, SEL, EXEC, EIPUPD, HALT. All strobes are combinational decodes of the state (plus `op_idx`). At most one strobe bit is high per cycle.
- RST: entered while `reset`=1. Goes to FETCH on the first cycle with `reset`=0.
- FETCH: `ph_fetch` = `fetch_ready`. If `fetch_ready`=1, go to DECODE; otherwise stay.
- DECODE: `ph_decode`=1 for one cycle, then go to DISPATCH.
- DISPATCH: sample `num_of_ope` into `ops_latched`.
  - Value 0: go to EIPUPD.
  - Values 1..3: go to SEL with `op_idx`=1.
  - Values >3: clamp to 3, set `illegal_ops`, go to SEL with `op_idx`=1.
- SEL: `ph_sel[op_idx-1]`=1, then go to EXEC.
- EXEC: `ph_exec[op_idx-1]`=1.
  - If `op_idx` < `ops_latched`: increment `op_idx`, go to SEL.
  - Otherwise: go to EIPUPD.
- EIPUPD: `ph_eip`=1 and `retired` increments by 1 (wraps at 2^CNT_W−1 → 0).
  - If `halt_req`=1: go to HALT.
  - Otherwise: go to FETCH.
- HALT: `halted`=1, no strobes. Go to FETCH on the first cycle `halt_req`=0.
- `halt_req` is sampled only in EIPUPD and HALT. Assertion mid-instruction never truncates an instruction.
- Reset overrides every state, including mid-instruction and HALT. The next instruction restarts at FETCH; partial micro-ops are abandoned.

## Timing
- Reset values: state RST; all strobes 0, `op_idx`=0, `ops_latched`=0, `illegal_ops`=0, `halted`=0, `retired`=0.
- First `ph_fetch` occurs on the second cycle after `reset` falls (one RST cycle), given `fetch_ready`=1.
- Instruction latency with no stall: 4 + 2·n cycles (n = latched ops). Values: n=0 → 4, n=1 → 6, n=2 → 8, n=3 → 10.
- Each `fetch_ready`-low cycle in FETCH adds 1 cycle.
- `retired` updates on the clock edge ending EIPUPD; it is visible in the following cycle.
- Back-to-back instructions: FETCH follows EIPUPD with zero idle cycles.
- Resume from HALT: FETCH is entered 1 cycle after `halt_req` falls.
- `illegal_ops` clears only on reset.

## Test plan
- Reset, then hold `fetch_ready`=1 and `num_of_ope`=3 → strobe order fetch, decode, sel[0], exec[0], sel[1], exec[1], sel[2], exec[2], eip; 10 cycles per instruction; `retired`=3 after 30 cycles.
- `num_of_ope` sequence 0, 1, 2 over three instructions → latencies 4, 6, 8 cycles; no sel/exec strobes for the n=0 instruction; `retired`=3.
- Hold `fetch_ready` low for 5 cycles at FETCH → FETCH held, `ph_fetch`=0 throughout; instruction takes 5 extra cycles; no other strobe asserts.
- Assert `halt_req` during EXEC of op 2 (n=3) → op 3 and EIPUPD still issue, then `halted`=1. Release → `ph_fetch` 1 cycle later; `retired` increments once.
- `num_of_ope`=7 → `illegal_ops`=1, `ops_latched`=3, 10-cycle instruction; flag stays set on the following instruction with `num_of_ope`=1.
- `reset` pulsed during SEL of op 2 → next cycle all outputs at reset values, `retired`=0; FETCH follows 1 cycle after release.
